// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the match sequencer: state encoding, winner codes and
// default timing constants.
package game_defs;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_t;

    localparam logic [1:0] WinNone  = 2'b00;
    localparam logic [1:0] WinLeft  = 2'b01;
    localparam logic [1:0] WinRight = 2'b10;

    localparam int unsigned DefWinScore    = 9;
    localparam int unsigned DefServeFrames = 120;
    localparam int unsigned DefPointFrames = 60;
    localparam int unsigned DefShrinkHits  = 8;
    localparam int unsigned DefMoveDiv     = 131072;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/game_flow_controller_tick_divider.sv
// Free-running strobe generator: one-cycle pulse every DIV cycles while en is
// high; counter is held at zero whenever en is low.
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pulse
);

    localparam logic [16:0] Last = 17'(DIV - 1);

    logic [16:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;

    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (en) begin
            if (cnt_q == Last) begin
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_flow_controller.sv
// Match sequencer: idle/serve/play/point/over FSM, scores, and the run/reset,
// bat-size and paddle-step controls derived from it.
module game_flow_controller
    import game_defs::*;
#(
    parameter int unsigned WIN_SCORE    = DefWinScore,
    parameter int unsigned SERVE_FRAMES = DefServeFrames,
    parameter int unsigned POINT_FRAMES = DefPointFrames,
    parameter int unsigned SHRINK_HITS  = DefShrinkHits,
    parameter int unsigned MOVE_DIV     = DefMoveDiv
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_n,
    input  logic       hit,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       bat_size,
    output logic       move_tick,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner
);

    localparam logic [7:0] ServeLast  = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] PointLast  = 8'(POINT_FRAMES - 1);
    localparam logic [7:0] ShrinkHits = 8'(SHRINK_HITS);
    localparam logic [3:0] WinScore   = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [7:0] rally_q, rally_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic       bat_size_q, bat_size_d;
    logic       ball_run_q, ball_run_d;
    logic       ball_reset_q, ball_reset_d;
    logic       sync1_q, sync2_q, sync3_q;
    logic       press;
    logic       move_en;

    // Idle level of start_n is high, so the synchronizer resets to 1 to avoid a false press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= start_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign press = sync3_q & ~sync2_q;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        rally_d     = rally_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        unique case (state_q)
            StIdle, StOver: begin
                if (press) begin
                    state_d     = StServe;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    winner_d    = WinNone;
                    serve_dir_d = 1'b0;
                end
            end
            StServe: begin
                if (frame_tick && frame_q == ServeLast) state_d = StPlay;
            end
            StPlay: begin
                if (miss_l) begin
                    score_r_d   = sat_inc4(score_r_q);
                    serve_dir_d = 1'b0;
                    state_d     = StPoint;
                end else if (miss_r) begin
                    score_l_d   = sat_inc4(score_l_q);
                    serve_dir_d = 1'b1;
                    state_d     = StPoint;
                end else if (hit && rally_q != ShrinkHits) begin
                    rally_d = rally_q + 8'd1;
                end
            end
            StPoint: begin
                if (frame_tick && frame_q == PointLast) begin
                    if (score_l_q == WinScore) begin
                        state_d  = StOver;
                        winner_d = WinLeft;
                    end else if (score_r_q == WinScore) begin
                        state_d  = StOver;
                        winner_d = WinRight;
                    end else begin
                        state_d = StServe;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A tick on the transition cycle is dropped because the counter clears instead.
        if (state_d != state_q) begin
            frame_d = '0;
        end else if (frame_tick && (state_q == StServe || state_q == StPoint)) begin
            frame_d = frame_q + 8'd1;
        end

        if (state_d != StPlay) rally_d = '0;

        bat_size_d   = (state_d == StPlay) && (rally_d == ShrinkHits);
        ball_run_d   = (state_d == StPlay);
        ball_reset_d = (state_d != StPlay);
    end

    // Only run while staying in PLAY, so no strobe lands on the exit cycle.
    assign move_en = (state_q == StPlay) && (state_d == StPlay);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            rally_q      <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_q     <= WinNone;
            serve_dir_q  <= 1'b0;
            bat_size_q   <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            rally_q      <= rally_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            bat_size_q   <= bat_size_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    tick_divider #(
        .DIV(MOVE_DIV)
    ) u_move_div (
        .clk  (clk),
        .rst  (rst),
        .en   (move_en),
        .pulse(move_tick)
    );

    assign state      = state_q;
    assign ball_run   = ball_run_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;
    assign bat_size   = bat_size_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed match scenario with literal checks,
// then randomized play compared every cycle against a behavioural model.
module tb_game_flow_controller;

    localparam int SF = 2, PF = 2, WS = 2, SH = 3, MD = 4;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0, start_n = 1'b1, hit = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic [2:0] state;
    logic       ball_run, ball_reset, serve_dir, bat_size, move_tick;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;

    int  checks = 0;
    int  failures = 0;
    bit  run_cmp = 1'b0;
    bit  sn = 1'b1;

    game_flow_controller #(
        .WIN_SCORE   (WS),
        .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF),
        .SHRINK_HITS (SH),
        .MOVE_DIV    (MD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start_n   (start_n),
        .hit       (hit),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .state     (state),
        .ball_run  (ball_run),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .bat_size  (bat_size),
        .move_tick (move_tick),
        .score_l   (score_l),
        .score_r   (score_r),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    // Behavioural model: match rules in plain integers.
    int m_state, m_sl, m_sr, m_win, m_dir, m_frames, m_hits, m_play_cycles;
    bit m_hist[3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = S_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0;
            m_frames = 0; m_hits = 0; m_play_cycles = 0;
            m_hist[0] = 1'b1; m_hist[1] = 1'b1; m_hist[2] = 1'b1;
        end else begin
            int  ns;
            bit  pressed;
            pressed   = m_hist[2] && !m_hist[1];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = start_n;
            ns = m_state;
            if (m_state == S_IDLE || m_state == S_OVER) begin
                if (pressed) begin
                    ns = S_SERVE; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0;
                end
            end else if (m_state == S_SERVE) begin
                if (frame_tick) m_frames++;
                if (m_frames == SF) ns = S_PLAY;
            end else if (m_state == S_PLAY) begin
                if (miss_l) begin
                    m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_dir = 0; ns = S_POINT;
                end else if (miss_r) begin
                    m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_dir = 1; ns = S_POINT;
                end else if (hit) begin
                    m_hits = (m_hits < SH) ? m_hits + 1 : SH;
                end
            end else if (m_state == S_POINT) begin
                if (frame_tick) m_frames++;
                if (m_frames == PF) begin
                    if (m_sl == WS) begin ns = S_OVER; m_win = 1; end
                    else if (m_sr == WS) begin ns = S_OVER; m_win = 2; end
                    else ns = S_SERVE;
                end
            end
            if (ns != m_state) m_frames = 0;
            if (ns != S_PLAY) m_hits = 0;
            if (m_state == S_PLAY && ns == S_PLAY) m_play_cycles++;
            else m_play_cycles = 0;
            m_state = ns;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            chk("state", int'(state), m_state);
            chk("score_l", int'(score_l), m_sl);
            chk("score_r", int'(score_r), m_sr);
            chk("winner", int'(winner), m_win);
            chk("serve_dir", int'(serve_dir), m_dir);
            chk("ball_run", int'(ball_run), int'(m_state == S_PLAY));
            chk("ball_reset", int'(ball_reset), int'(m_state != S_PLAY));
            chk("bat_size", int'(bat_size), int'(m_state == S_PLAY && m_hits == SH));
            chk("move_tick", int'(move_tick),
                int'(m_state == S_PLAY && m_play_cycles > 0 && m_play_cycles % MD == 0));
        end
    end

    task automatic step(input bit ft, input bit h, input bit ml, input bit mr);
        @(posedge clk);
        #2;
        frame_tick = ft; hit = h; miss_l = ml; miss_r = mr; start_n = sn;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic press();
        sn = 1'b0;
        idle_steps(4);
    endtask

    task automatic release_start();
        sn = 1'b1;
        idle_steps(2);
    endtask

    task automatic two_frames();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        int ticks;
        #23 rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_ball_reset", int'(ball_reset), 1);
        chk("rst_ball_run", int'(ball_run), 0);
        chk("rst_scores", int'({score_l, score_r}), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_misc", int'({serve_dir, bat_size, move_tick}), 0);
        run_cmp = 1'b1;

        press();
        chk("press_serve", int'(state), S_SERVE);
        release_start();
        two_frames();
        chk("serve_to_play", int'(state), S_PLAY);
        chk("play_ball_run", int'(ball_run), 1);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0);
            ticks += int'(move_tick);
        end
        chk("move_ticks_12cyc", ticks, 3);

        step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("bat_before_3rd", int'(bat_size), 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        chk("bat_small", int'(bat_size), 1);

        step(0, 0, 0, 1); step(0, 0, 0, 0);
        chk("miss_r_state", int'(state), S_POINT);
        chk("miss_r_score_l", int'(score_l), 1);
        chk("miss_r_dir", int'(serve_dir), 1);
        chk("point_bat", int'(bat_size), 0);
        two_frames();
        chk("point_to_serve", int'(state), S_SERVE);
        two_frames();
        press();
        release_start();
        chk("press_in_play", int'(state), S_PLAY);

        step(0, 1, 1, 1); step(0, 0, 0, 0);
        chk("both_score_r", int'(score_r), 1);
        chk("both_score_l", int'(score_l), 1);
        chk("both_dir", int'(serve_dir), 0);
        two_frames();
        two_frames();
        step(0, 0, 0, 1); step(0, 0, 0, 0);
        chk("second_point", int'(score_l), 2);
        two_frames();
        chk("over_state", int'(state), S_OVER);
        chk("over_winner", int'(winner), 1);

        press();
        chk("restart_state", int'(state), S_SERVE);
        chk("restart_scores", int'({score_l, score_r, winner}), 0);
        release_start();
        two_frames();
        step(0, 0, 0, 1); step(0, 0, 0, 0);
        two_frames();
        two_frames();
        chk("pre_rst_play", int'(state), S_PLAY);
        chk("pre_rst_score", int'(score_l), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state), S_IDLE);
        chk("async_rst_score", int'(score_l), 0);
        chk("async_rst_ball_reset", int'(ball_reset), 1);
        chk("async_rst_ball_run", int'(ball_run), 0);
        @(negedge clk); #2 rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11) == 0) sn = ~sn;
            step($urandom_range(2) == 0, $urandom_range(3) == 0,
                 $urandom_range(15) == 0, $urandom_range(15) == 0);
        end
        idle_steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level match sequencer for the ball-and-paddle game. It owns the match state machine (idle, serve, play, point, game-over) and keeps both scores. It issues the run/reset controls to the ball logic, the bat-size select and a movement-rate strobe to both paddle controllers. It sits between the video timing (frame tick), the ball logic (hit/miss events) and the paddle controllers.

## Interface
- WIN_SCORE, 9: points needed to win, 1..15.
- SERVE_FRAMES, 120: frame ticks spent in SERVE before play starts, ≥1.
- POINT_FRAMES, 60: frame ticks spent in POINT after a miss, ≥1.
- SHRINK_HITS, 8: paddle hits within one rally before `bat_size` goes to 1, 1..255.
- MOVE_DIV, 131072: `move_tick` period in clk cycles, ≥2, ≤2^17.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_n  in  1  start button, active-low, asynchronous to clk.
- hit  in  1  one-cycle pulse when either paddle returns the ball.
- miss_l  in  1  one-cycle pulse when the ball passes the left paddle.
- miss_r  in  1  one-cycle pulse when the ball passes the right paddle.
- state  out  3  current FSM state (encoding in package).
- ball_run  out  1  ball may move.
- ball_reset  out  1  hold ball at centre.
- serve_dir  out  1  0 = serve toward left player, 1 = toward right.
- bat_size  out  1  0 = large bat, 1 = small bat.
- move_tick  out  1  one-cycle paddle step strobe.
- score_l, score_r  out  4 each  player scores.
- winner  out  2  00 none, 01 left, 10 right.

## Operation
- Reset values:
  - state = IDLE, ball_run = 0, ball_reset = 1, serve_dir = 0, bat_size = 0, move_tick = 0.
  - scores = 0, winner = 00, all internal counters = 0.
- start_n passes through a 2-flop synchronizer. A "start press" is a synchronized 1→0 transition, detected with one extra flop.
- IDLE:
  - ball_reset = 1.
  - Start press → SERVE. Scores, winner and serve_dir are all cleared.
- SERVE:
  - ball_reset = 1, ball_run = 0.
  - The frame counter counts frame_tick. On the SERVE_FRAMES-th tick → PLAY.
- PLAY:
  - ball_reset = 0, ball_run = 1.
  - The move divider runs. `move_tick` pulses on every MOVE_DIV-th clk, first pulse MOVE_DIV cycles after PLAY entry.
  - hit increments an 8-bit rally counter, saturating at SHRINK_HITS. Counter == SHRINK_HITS → bat_size = 1.
  - miss_l: score_r += 1, serve_dir = 0, → POINT.
  - miss_r: score_l += 1, serve_dir = 1, → POINT.
  - miss_l and miss_r in the same cycle: miss_l wins and miss_r is dropped.
  - hit in the same cycle as a miss is ignored.
- POINT:
  - ball_run = 0, ball_reset = 1, move_tick = 0.
  - Rally counter and bat_size are cleared on entry.
  - After POINT_FRAMES frame ticks:
    - if either score == WIN_SCORE → OVER, with winner set (01 left, 10 right);
    - else → SERVE.
- OVER:
  - ball_reset = 1. Scores and winner hold.
  - Start press → SERVE with scores and winner cleared and serve_dir = 0.
- Start presses in SERVE, PLAY and POINT are ignored.
- hit and miss pulses outside PLAY are ignored.
- Scores are 4-bit and saturate at 15; with WIN_SCORE ≤ 15 they never reach saturation.
- The frame counter (8 bits, wide enough for the defaults) is cleared on every state change. A frame_tick in the entry cycle is not counted.
- The move divider (17 bits) is held at 0 outside PLAY.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Event input (hit, miss) at cycle n → state, score and serve_dir updated at n+1.
- Start press: start_n falls at cycle n → state = SERVE no earlier than n+3 (2 synchronizer stages + edge detect).
- SERVE exit: on the cycle after the SERVE_FRAMES-th frame tick; POINT exit uses POINT_FRAMES the same way.
- move_tick is high for exactly 1 cycle.
- No move_tick is issued on the cycle the FSM leaves PLAY.
- Async rst mid-match returns every output to its reset value immediately; no score is retained.

## Structure
- Package `game_defs`:
  - state encoding: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;
  - winner codes;
  - default parameter constants.
- Sub-module `tick_divider` (parameter DIV, inputs clk/rst/en, output 1-cycle pulse). Used for move_tick. The frame counter stays inline in the FSM.

## Test plan
- Run with SERVE_FRAMES = 2, POINT_FRAMES = 2, MOVE_DIV = 4 and WIN_SCORE = 2 unless a scenario says otherwise.
- Reset then start press → SERVE; after 2 frame ticks → PLAY with ball_run = 1; move_tick every 4 clocks; outputs match the reset list before the press.
- In PLAY, miss_r pulse → next cycle POINT, score_l = 1, serve_dir = 1; after 2 frame ticks → SERVE.
- miss_l and miss_r in the same cycle → score_r = 1, score_l = 0, serve_dir = 0.
- SHRINK_HITS = 3: 3 hit pulses → bat_size = 1 on the cycle after the third; a following miss → bat_size = 0 on POINT entry.
- Two left-player points → OVER, winner = 01. Start presses during play have no effect. A start press in OVER → SERVE with scores 0 and winner 00.
- Assert rst during PLAY with score_l = 1 → state IDLE, scores 0, ball_reset = 1 without waiting for a clock edge.
